tick_div_arbiter: RTL and testbench

//  Shares the single programmable enable-tick divider between N_REQ requesters.
//  Per burst: accepts a request (div ratio + tick count) by round-robin, programs
//  the divider, holds it in reset to settle, then forwards exactly the requested

---
 rtl/tick_div_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_tick_div_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_div_arbiter.sv
// Round-robin owner of the shared enable-tick divider: grants one requester per burst,
// reprograms and settles the divider, forwards the requested number of ticks, reports status.
module tick_div_arbiter #(
    parameter int N_REQ      = 2,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 2,
    parameter int OWN_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_div,
    input  logic [CNT_W*N_REQ-1:0] req_cnt,
    input  logic [N_REQ-1:0]       abort,
    output logic [2:0]             div_sel,
    output logic                   div_rst,
    input  logic                   tick_in,
    output logic [N_REQ-1:0]       tick_out,
    output logic                   busy,
    output logic [OWN_W-1:0]       owner,
    output logic [N_REQ-1:0]       done,
    output logic [1:0]             status
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [OWN_W-1:0] last_grant_q, last_grant_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [2:0]       div_sel_q, div_sel_d;
    logic             div_rst_q, div_rst_d;
    logic             busy_q, busy_d;
    logic [1:0]       status_q, status_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic [N_REQ-1:0] tick_out_q, tick_out_d;
    logic [N_REQ-1:0] done_q, done_d;

    logic             found;
    logic [OWN_W-1:0] win;
    logic [2:0]       win_div;
    logic [CNT_W-1:0] win_cnt;
    logic             own_abort;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = OWN_W'(idx);
            end
        end
    end

    assign win_div   = req_div[3*int'(win) +: 3];
    assign win_cnt   = req_cnt[CNT_W*int'(win) +: CNT_W];
    assign own_abort = abort[owner_q];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        remaining_d  = remaining_q;
        settle_d     = settle_q;
        div_sel_d    = div_sel_q;
        status_d     = status_q;
        req_ready_d  = '0;
        tick_out_d   = '0;
        done_d       = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d          = win;
                    remaining_d      = win_cnt;
                    req_ready_d[win] = 1'b1;
                    if (win_div == 3'd0 || win_cnt == '0) begin
                        state_d  = S_DONE;
                        status_d = 2'b10;
                    end else begin
                        state_d   = S_LOAD;
                        div_sel_d = win_div;
                    end
                end
            end
            S_LOAD: begin
                settle_d = '0;
                if (own_abort) begin
                    state_d  = S_DONE;
                    status_d = 2'b01;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (own_abort) begin
                    state_d  = S_DONE;
                    status_d = 2'b01;
                end else if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                    state_d = S_RUN;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_RUN: begin
                // A tick coinciding with abort is still counted and forwarded.
                if (tick_in) begin
                    remaining_d         = remaining_q - 1'b1;
                    tick_out_d[owner_q] = 1'b1;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d  = S_DONE;
                        status_d = 2'b00;
                    end else if (own_abort) begin
                        state_d  = S_DONE;
                        status_d = 2'b01;
                    end
                end else if (own_abort) begin
                    state_d  = S_DONE;
                    status_d = 2'b01;
                end
            end
            S_DONE: begin
                last_grant_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE) done_d[owner_d] = 1'b1;
    end

    assign busy_d    = (state_d != S_IDLE);
    assign div_rst_d = (state_d != S_RUN);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            last_grant_q <= OWN_W'(N_REQ - 1);
            owner_q      <= '0;
            remaining_q  <= '0;
            settle_q     <= '0;
            div_sel_q    <= 3'd1;
            div_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            status_q     <= 2'b00;
            req_ready_q  <= '0;
            tick_out_q   <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            remaining_q  <= remaining_d;
            settle_q     <= settle_d;
            div_sel_q    <= div_sel_d;
            div_rst_q    <= div_rst_d;
            busy_q       <= busy_d;
            status_q     <= status_d;
            req_ready_q  <= req_ready_d;
            tick_out_q   <= tick_out_d;
            done_q       <= done_d;
        end
    end

    assign req_ready = req_ready_q;
    assign div_sel   = div_sel_q;
    assign div_rst   = div_rst_q;
    assign tick_out  = tick_out_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign done      = done_q;
    assign status    = status_q;

endmodule

// File: tb/tb_tick_div_arbiter.sv
// Scoreboard bench for tick_div_arbiter: stimulus pushes expected grants and burst
// results; negedge monitors pop and compare whenever req_ready or done appear.
module tb_tick_div_arbiter;

    localparam int N_REQ = 2;
    localparam int CNT_W = 16;
    localparam int SETTLE_CYC = 2;
    localparam int OWN_W = 1;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [3*N_REQ-1:0]     req_div = '0;
    logic [CNT_W*N_REQ-1:0] req_cnt = '0;
    logic [N_REQ-1:0]       abort = '0;
    logic [2:0]             div_sel;
    logic                   div_rst;
    logic                   tick_in;
    logic [N_REQ-1:0]       tick_out;
    logic                   busy;
    logic [OWN_W-1:0]       owner;
    logic [N_REQ-1:0]       done;
    logic [1:0]             status;

    logic manual = 1'b0;
    logic tick_man = 1'b0;
    logic tick_mdl = 1'b0;
    int   dcnt = 0;

    assign tick_in = manual ? tick_man : tick_mdl;

    tick_div_arbiter #(.N_REQ(N_REQ), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC), .OWN_W(OWN_W)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_div(req_div), .req_cnt(req_cnt), .abort(abort), .div_sel(div_sel),
        .div_rst(div_rst), .tick_in(tick_in), .tick_out(tick_out), .busy(busy),
        .owner(owner), .done(done), .status(status)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [N_REQ-1:0] mask;
        logic [1:0]       st;
        int               ticks;
        bit               rel;
        int               gap;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Enable-tick divider model: one tick every div_sel cycles while released.
    always @(negedge CLK) begin
        if (RST || div_rst) begin
            dcnt = 0;
            tick_mdl = 1'b0;
        end else if (dcnt >= int'(div_sel) - 1) begin
            dcnt = 0;
            tick_mdl = 1'b1;
        end else begin
            dcnt++;
            tick_mdl = 1'b0;
        end
    end

    // Burst monitor
    int m_cyc = 0, m_ticks = 0, m_last = 0, m_gap = 0;
    bit m_rel = 0;
    logic [N_REQ-1:0] m_mask = '0;
    always @(negedge CLK) begin
        exp_t e;
        m_cyc++;
        if (RST) begin
            m_ticks = 0; m_gap = 0; m_rel = 0; m_mask = '0;
        end else begin
            if (req_ready != '0) begin
                if (grant_q.size() == 0) chk("unexpected_grant", 32'(req_ready), 0);
                else chk("grant", 32'(req_ready), 32'(1) << grant_q.pop_front());
            end
            if (tick_out != '0) begin
                if (m_ticks > 0) m_gap = m_cyc - m_last;
                m_last = m_cyc;
                m_ticks++;
                m_mask |= tick_out;
            end
            if (!div_rst) m_rel = 1;
            if (done != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_mask", 32'(done), 32'(e.mask));
                    chk("status", 32'(status), 32'(e.st));
                    chk("tick_count", m_ticks, e.ticks);
                    chk("div_released", 32'(m_rel), 32'(e.rel));
                    chk("tick_gap", m_gap, e.gap);
                    chk("tick_owner", 32'(m_mask), (e.ticks > 0) ? 32'(e.mask) : 0);
                end
                m_ticks = 0; m_gap = 0; m_rel = 0; m_mask = '0;
            end
        end
    end

    task automatic push_exp(input int who, input logic [1:0] st, input int ticks, input bit rel, input int gap);
        exp_t e;
        e.mask = N_REQ'(1) << who;
        e.st = st; e.ticks = ticks; e.rel = rel; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Raises req_valid[idx] and returns at the negedge where req_ready[idx] shows.
    task automatic issue(input int idx, input logic [2:0] d, input int c);
        int n;
        @(negedge CLK);
        req_div[3*idx +: 3] = d;
        req_cnt[CNT_W*idx +: CNT_W] = CNT_W'(c);
        req_valid[idx] = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!req_ready[idx] && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready[idx]) chk("ready_timeout", 0, 1);
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        int n, seen;

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_div_rst", 32'(div_rst), 1);
        chk("rst_div_sel", 32'(div_sel), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_outputs", {req_ready, tick_out, done}, 0);
        RST = 1'b0;

        // Basic burst: div=3, cnt=4
        grant_q.push_back(0);
        push_exp(0, 2'b00, 4, 1, 3);
        issue(0, 3'd3, 4);
        chk("load_div_sel", 32'(div_sel), 3);
        chk("load_busy", 32'(busy), 1);
        chk("load_owner", 32'(owner), 0);
        n = 0;
        while (div_rst && n < 20) begin
            n++;
            @(negedge CLK);
        end
        chk("div_rst_hold", n, 1 + SETTLE_CYC);
        wait_drain();

        // Simultaneous requests, round-robin over four bursts
        do_reset();
        @(negedge CLK);
        req_div = {3'd1, 3'd1};
        req_cnt = {CNT_W'(2), CNT_W'(2)};
        for (int i = 0; i < 4; i++) begin
            grant_q.push_back(i % 2);
            push_exp(i % 2, 2'b00, 2, 1, 1);
        end
        req_valid = 2'b11;
        seen = 0; n = 0;
        while (seen < 4 && n < 400) begin
            @(negedge CLK);
            n++;
            if (req_ready != '0) seen++;
        end
        req_valid = '0;
        chk("rr_grants_seen", seen, 4);
        wait_drain();

        // Bad configuration: cnt=0 then div=0
        grant_q.push_back(1);
        push_exp(1, 2'b10, 0, 0, 0);
        issue(1, 3'd3, 0);
        wait_drain();
        grant_q.push_back(1);
        push_exp(1, 2'b10, 0, 0, 0);
        issue(1, 3'd0, 5);
        wait_drain();

        // Abort after third tick; earlier non-owner abort ignored
        grant_q.push_back(0);
        push_exp(0, 2'b01, 3, 1, 3);
        issue(0, 3'd3, 10);
        seen = 0; n = 0;
        while (seen < 3 && n < 200) begin
            @(negedge CLK);
            n++;
            abort = '0;
            if (tick_out[0]) begin
                seen++;
                if (seen == 1) abort = 2'b10;
                if (seen == 3) abort = 2'b01;
            end
        end
        @(negedge CLK);
        abort = '0;
        wait_drain();

        // Abort coincident with final tick (cnt=2) keeps status ok
        manual = 1'b1;
        grant_q.push_back(0);
        push_exp(0, 2'b00, 2, 1, 3);
        issue(0, 3'd2, 2);
        n = 0;
        while (div_rst && n < 20) begin
            @(negedge CLK);
            n++;
        end
        tick_man = 1'b1;
        @(negedge CLK); tick_man = 1'b0;
        @(negedge CLK);
        @(negedge CLK); tick_man = 1'b1; abort = 2'b01;
        @(negedge CLK); tick_man = 1'b0; abort = 2'b00;
        wait_drain();
        manual = 1'b0;

        // Reset in RUN: no done pulse, new request accepted afterwards
        grant_q.push_back(0);
        issue(0, 3'd3, 10);
        n = 0;
        while (!tick_out[0] && n < 50) begin
            @(negedge CLK);
            n++;
        end
        RST = 1'b1;
        #1;
        chk("midrst_div_rst", 32'(div_rst), 1);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        grant_q.push_back(1);
        push_exp(1, 2'b00, 1, 1, 0);
        issue(1, 3'd2, 1);
        wait_drain();

        chk("exp_queue_empty", exp_q.size(), 0);
        chk("grant_queue_empty", grant_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
